// File: rtl/dom_mult_scheduler.sv
// dom_mult_scheduler
// Shares one combinational DOM dependent-input GF(2^2) multiplier among NREQ
// requesters. A round-robin arbiter issues at most one op per cycle. Each op
// gets fresh randomness (z0, z1) from an internal LFSR. Operands are
// registered before the multiplier and results are registered after it, so no
// glitchy combinational path leaves the block.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   seed_valid, seed_data    load LFSR seed (zero seed -> LFSR_INIT)
//   req_valid / req_ready    per-requester handshake, req_ready is a one-hot grant
//   req_ax/ay/bx/by          share pairs, requester i uses bits [2i+1:2i]
//   rsp_valid / rsp_ready    result handshake
//   rsp_id, rsp_aq, rsp_bq   requester index and output shares
//   seeded                   LFSR has been loaded since reset
//   op_count                 number of accepted ops, wraps at 16 bits
//
// state   | meaning
// ST_SEED | waiting for the first seed, no grants
// ST_RUN  | arbitrating and issuing ops, seed reloads allowed
module dom_mult_scheduler #(
  parameter int          NREQ      = 4,
  parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_valid,
  input  logic [15:0]       seed_data,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_ax,
  input  logic [2*NREQ-1:0] req_ay,
  input  logic [2*NREQ-1:0] req_bx,
  input  logic [2*NREQ-1:0] req_by,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_id,
  output logic [1:0]        rsp_aq,
  output logic [1:0]        rsp_bq,
  output logic              seeded,
  output logic [15:0]       op_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_SEED, ST_RUN} state_t;

  state_t        state, state_next;
  logic [15:0]   lfsr;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_idx;
  logic [IW:0]   cand;
  logic [IW:0]   gnt_sel;
  logic          grant;
  logic          can_issue;
  logic          s1_move;
  logic          s1_valid;
  logic [1:0]    s1_ax, s1_ay, s1_bx, s1_by, s1_z0, s1_z1;
  logic [IW-1:0] s1_id;
  logic [1:0]    mul_aq, mul_bq;

  // GF(2^2) with field polynomial x^2 + x + 1
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    logic hi;
    hi = a[1] & b[1];
    return {hi ^ (a[1] & b[0]) ^ (a[0] & b[1]), hi ^ (a[0] & b[0])};
  endfunction

  // Four Fibonacci steps of x^16+x^14+x^13+x^11+1, shifting left
  function automatic logic [15:0] lfsr_adv4(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= ST_SEED;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_SEED: if (seed_valid) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_SEED;
    endcase
  end

  assign s1_move   = !rsp_valid || rsp_ready;
  assign can_issue = (state == ST_RUN) && (!s1_valid || s1_move);

  // Circular search starting at ptr; the first valid requester wins
  always_comb begin
    grant   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (can_issue && !grant && req_valid[cand[IW-1:0]]) begin
        grant   = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
  end

  assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;
  assign gnt_sel   = {gnt_idx, 1'b0};

  // Multiplier sees registered operands only
  assign mul_aq = gf4_mul(s1_ax, s1_ay ^ s1_by ^ s1_z0) ^ (gf4_mul(s1_ax, s1_z0) ^ s1_z1);
  assign mul_bq = gf4_mul(s1_bx, s1_by ^ s1_ay ^ s1_z0) ^ (gf4_mul(s1_bx, s1_z0) ^ s1_z1);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= LFSR_INIT;
      seeded    <= 1'b0;
      ptr       <= '0;
      op_count  <= '0;
      s1_valid  <= 1'b0;
      s1_ax     <= '0;
      s1_ay     <= '0;
      s1_bx     <= '0;
      s1_by     <= '0;
      s1_z0     <= '0;
      s1_z1     <= '0;
      s1_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_aq    <= '0;
      rsp_bq    <= '0;
    end else begin
      // A seed load takes priority over the advance of an op accepted this
      // cycle; that op has already captured the pre-load z bits.
      if (seed_valid) begin
        lfsr   <= (seed_data == 16'h0000) ? LFSR_INIT : seed_data;
        seeded <= 1'b1;
      end else if (grant) begin
        lfsr <= lfsr_adv4(lfsr);
      end

      if (!s1_valid || s1_move) s1_valid <= grant;

      if (grant) begin
        s1_ax    <= req_ax[gnt_sel +: 2];
        s1_ay    <= req_ay[gnt_sel +: 2];
        s1_bx    <= req_bx[gnt_sel +: 2];
        s1_by    <= req_by[gnt_sel +: 2];
        s1_z0    <= lfsr[1:0];
        s1_z1    <= lfsr[3:2];
        s1_id    <= gnt_idx;
        ptr      <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);
        op_count <= op_count + 16'd1;
      end

      if (s1_move) rsp_valid <= s1_valid;

      if (s1_valid && s1_move) begin
        rsp_id <= 3'(s1_id);
        rsp_aq <= mul_aq;
        rsp_bq <= mul_bq;
      end
    end
  end

endmodule

// File: tb/tb_dom_mult_scheduler.sv
// tb_dom_mult_scheduler
// Directed bench for dom_mult_scheduler (NREQ=4). An in-order queue records
// each accepted op with the z bits a reference LFSR predicts, and every
// response is compared against the DOM share equations and the unmasked
// GF(2^2) product computed from a log/antilog table.
module tb_dom_mult_scheduler;

  localparam logic [15:0] INIT = 16'hACE1;

  logic        clk;
  logic        rst;
  logic        seed_valid;
  logic [15:0] seed_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_ax, req_ay, req_bx, req_by;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_id;
  logic [1:0]  rsp_aq, rsp_bq;
  logic        seeded;
  logic [15:0] op_count;

  dom_mult_scheduler #(.NREQ(4), .LFSR_INIT(INIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ax     (req_ax),
    .req_ay     (req_ay),
    .req_bx     (req_bx),
    .req_by     (req_by),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_aq     (rsp_aq),
    .rsp_bq     (rsp_bq),
    .seeded     (seeded),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] id;
    logic [1:0] ax, ay, bx, by, z0, z1;
  } op_t;

  op_t         q[$];
  logic [15:0] lfsr_m;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_acc = 0;
  int          n_rsp = 0;
  int          last_gnt;
  logic [1:0]  last_aq;
  int          acc0, rsp0;
  logic        any_rdy, any_rsp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // GF(4) via logs: generator x (=2), 2^0=1, 2^1=2, 2^2=3
  function automatic logic [1:0] gf_ref(input logic [1:0] a, input logic [1:0] b);
    int la, lb;
    logic [1:0] alog [3];
    alog[0] = 2'd1; alog[1] = 2'd2; alog[2] = 2'd3;
    if (a == 2'd0 || b == 2'd0) return 2'd0;
    la = (a == 2'd1) ? 0 : (a == 2'd2) ? 1 : 2;
    lb = (b == 2'd1) ? 0 : (b == 2'd2) ? 1 : 2;
    return alog[(la + lb) % 3];
  endfunction

  function automatic logic [15:0] lfsr_step4(input logic [15:0] v);
    logic [15:0] r;
    logic fb;
    r = v;
    for (int i = 0; i < 4; i++) begin
      fb = r[15] ^ r[13] ^ r[12] ^ r[10];
      r  = {r[14:0], fb};
    end
    return r;
  endfunction

  // One clock: sample handshakes before the edge, update the model, then
  // return 1 time unit after the edge so callers can drive the next inputs.
  task automatic cycle();
    op_t e;
    int  g;
    #1;
    g = -1;
    for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) g = i;
    last_gnt = g;
    if (rst) begin
      q.delete();
      lfsr_m = INIT;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_aq", rsp_aq, gf_ref(e.ax, e.ay ^ e.by ^ e.z0) ^ gf_ref(e.ax, e.z0) ^ e.z1);
          chk("rsp_bq", rsp_bq, gf_ref(e.bx, e.by ^ e.ay ^ e.z0) ^ gf_ref(e.bx, e.z0) ^ e.z1);
          chk("recombine", rsp_aq ^ rsp_bq, gf_ref(e.ax ^ e.bx, e.ay ^ e.by));
          last_aq = rsp_aq;
          n_rsp++;
        end
      end
      if (g >= 0) begin
        e.id = 3'(g);
        e.ax = req_ax[2*g +: 2];
        e.ay = req_ay[2*g +: 2];
        e.bx = req_bx[2*g +: 2];
        e.by = req_by[2*g +: 2];
        e.z0 = lfsr_m[1:0];
        e.z1 = lfsr_m[3:2];
        q.push_back(e);
        n_acc++;
      end
      if (seed_valid) lfsr_m = (seed_data == 16'h0000) ? INIT : seed_data;
      else if (g >= 0) lfsr_m = lfsr_step4(lfsr_m);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; seed_valid = 1'b0; seed_data = '0; req_valid = '0;
    req_ax = '0; req_ay = '0; req_bx = '0; req_by = '0; rsp_ready = 1'b1;
    lfsr_m = INIT; last_aq = '0; last_gnt = -1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_op_count", op_count, 0);
    chk("reset_seeded", seeded, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_shares", {rsp_aq, rsp_bq}, 0);

    // No seed: nothing may be granted
    any_rdy = 1'b0; any_rsp = 1'b0;
    repeat (20) begin
      cycle();
      any_rdy |= (req_ready != 4'h0);
      any_rsp |= rsp_valid;
    end
    chk("noseed_ready", any_rdy, 0);
    chk("noseed_rsp", any_rsp, 0);
    chk("noseed_seeded", seeded, 0);

    // Zero seed maps to INIT; single op from requester 2
    req_valid = '0; seed_valid = 1'b1; seed_data = 16'h0000;
    cycle();
    seed_valid = 1'b0;
    chk("seed_flag", seeded, 1);
    req_valid = 4'b0100;
    req_ax = 8'h20; req_ay = 8'h30; req_bx = 8'h10; req_by = 8'h10;
    #1;
    chk("single_ready", req_ready, 4'b0100);
    cycle();
    chk("lat_t1", rsp_valid, 0);
    req_valid = '0;
    cycle();
    chk("lat_t2", rsp_valid, 1);
    chk("single_id", rsp_id, 2);
    // ax=2 ay=3 bx=1 by=1, z0=01 z1=00 from 16'hACE1
    chk("single_aq", rsp_aq, 2'd3);
    chk("single_bq", rsp_bq, 2'd2);
    cycle();

    // All 256 share combinations through requester 2 at full rate
    req_valid = 4'b0100;
    for (int i = 0; i < 256; i++) begin
      req_ax = 8'((i >> 6) & 3) << 4;
      req_ay = 8'((i >> 4) & 3) << 4;
      req_bx = 8'((i >> 2) & 3) << 4;
      req_by = 8'(i & 3) << 4;
      cycle();
    end
    req_valid = '0;
    repeat (3) cycle();
    chk("sweep_drained", q.size(), 0);
    chk("sweep_count", op_count, 257);

    // Round robin from a fresh reset
    rst = 1'b1;
    cycle();
    rst = 1'b0; seed_valid = 1'b1; seed_data = 16'h0000;
    cycle();
    seed_valid = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      req_ax = 8'(k * 37); req_ay = 8'(k * 91 + 5);
      req_bx = 8'(k * 53 + 17); req_by = 8'(k * 29 + 200);
      cycle();
      chk("rr_grant", last_gnt, k % 4);
    end
    req_valid = '0;
    chk("rr_op_count", op_count, 8);
    repeat (3) cycle();
    chk("rr_drained", q.size(), 0);

    // Backpressure
    rsp_ready = 1'b0; req_valid = 4'hF;
    acc0 = n_acc;
    repeat (5) cycle();
    chk("bp_accepts", n_acc - acc0, 2);
    chk("bp_ready", req_ready, 0);
    rsp_ready = 1'b1; req_valid = '0;
    rsp0 = n_rsp;
    repeat (4) cycle();
    chk("bp_drain", n_rsp - rsp0, 2);
    chk("bp_empty", q.size(), 0);

    // Seed load coincident with a grant; ax=0 makes aq equal z1
    req_valid = 4'b0001;
    req_ax = 8'h00; req_ay = 8'h02; req_bx = 8'h03; req_by = 8'h01;
    seed_valid = 1'b1; seed_data = 16'h1234;
    cycle();
    seed_valid = 1'b0;
    cycle();
    req_valid = '0;
    repeat (3) cycle();
    chk("seed_new_z1", last_aq, 2'b01);
    chk("seed_empty", q.size(), 0);

    // Reset with two ops in flight
    req_valid = 4'hF;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_seeded", seeded, 0);
    rst = 1'b0;
    cycle();
    chk("rst_no_rsp", rsp_valid, 0);
    chk("rst_need_seed", req_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
